instr_fetch_unit: RTL
=====================

INSTR_FETCH_UNIT -- requirements
Module: instr_fetch_unit

Interface
REQ-001 Parameter: RESET_PC, 32'h0000_0000, PC value loaded at reset.
REQ-002 Parameter: IMEM_LAT_MAX, 8, cycles allowed before imem_ack with no ack sets fetch_err.
REQ-003 clk  input  1  single clock; all state updates on rising edge.
REQ-004 rst_n  input  1  reset, asynchronous assert, active-low.
REQ-005 pcsource  input  2  next-PC select from control unit: 00 seq, 01 branch, 10 jr, 11 j/jal.
REQ-006 imm16  input  16  branch offset, instr[15:0].
REQ-007 target26  input  26  jump index, instr[25:0].
REQ-008 jr_addr  input  32  rs register value for jr.
REQ-009 advance  input  1  datapath has finished the current instruction.
REQ-010 imem_req  output  1  instruction memory read request.
REQ-011 imem_addr  output  32  word-aligned read address.
REQ-012 imem_ack  input  1  read data valid on imem_rdata.
REQ-013 imem_rdata  input  32  instruction word.
REQ-014 instr  output  32  instruction register.
REQ-015 op  output  6  instr[31:26].
REQ-016 func  output  6  instr[5:0].
REQ-017 instr_valid  output  1  instr holds the instruction at pc.
REQ-018 pc  output  32  address of the current instruction.
REQ-019 pc_plus4  output  32  pc + 4, combinational, for jal link.
REQ-020 addr_err  output  1  one-cycle pulse on misaligned jr target.
REQ-021 fetch_err  output  1  sticky, set on memory timeout.

Function
REQ-022 The FSM SHALL have exactly three states: FETCH, WAIT, EXEC.
REQ-023 FETCH: imem_req=1, imem_addr=pc; imem_ack in the same cycle -> load instr, go EXEC; else go WAIT.
REQ-024 WAIT: imem_req held 1, imem_addr held stable; on imem_ack -> load instr, go EXEC.
REQ-025 Fetch latency: instr_valid SHALL rise the cycle after the ack cycle.
REQ-026 EXEC: imem_req=0, instr_valid=1; instr and pc frozen until advance=1.
REQ-027 On advance=1 in EXEC: pc <= next_pc, instr_valid <= 0, go FETCH.
REQ-028 advance SHALL be ignored in FETCH and WAIT.
REQ-029 next_pc: 00 -> pc+4; 01 -> pc+4 + (sign-extended imm16 << 2); 10 -> {jr_addr[31:2],2'b00}; 11 -> {pc_plus4[31:28],target26,2'b00}.
REQ-030 All PC arithmetic is modulo 2^32: 32'hFFFF_FFFC + 4 = 32'h0000_0000, no error.
REQ-031 pcsource=10 with jr_addr[1:0]!=0: addr_err pulses for the advance cycle; target truncated per REQ-029.
REQ-032 WAIT cycle counter reaching IMEM_LAT_MAX: fetch_err<=1, FSM stays in WAIT, request held.
REQ-033 fetch_err clears only on reset.
REQ-034 imem_ack outside FETCH/WAIT SHALL be ignored.

Reset
REQ-035 rst_n=0 SHALL immediately force: state=FETCH, pc=RESET_PC, instr=0, instr_valid=0, addr_err=0, fetch_err=0, WAIT counter=0.
REQ-036 imem_req SHALL be 0 while rst_n=0 and rise on the first clock after release.
REQ-037 Reset during WAIT abandons the request; a late imem_ack after release SHALL NOT load instr unless the FSM is in FETCH or WAIT.

Structure
REQ-038 The pcsource encodings (PCSRC_SEQ/BR/JR/J) and RESET_PC default SHALL live in the shared include file, used by both the control unit and this block.
REQ-039 Next-PC computation SHALL be a combinational sub-module, next_pc_gen; the FSM, counter and registers stay in instr_fetch_unit.

Verification
REQ-040 Reset release, imem acks in the request cycle with 32'h2008_0005 -> instr_valid at cycle 2, op=6'b001000, pc=0.
REQ-041 pc=32'h0000_0040, pcsource=01, imm16=16'hFFFE, advance -> next imem_addr=32'h0000_003C.
REQ-042 pc=32'h1000_0010, pcsource=11, target26=26'h000_0100 -> imem_addr=32'h1000_0400.
REQ-043 pcsource=10, jr_addr=32'h0000_0103 -> addr_err pulses 1 cycle, imem_addr=32'h0000_0100.
REQ-044 imem_ack withheld 8 cycles -> fetch_err=1, imem_req and imem_addr stable; ack at cycle 10 -> instr loads, fetch_err stays 1.
REQ-045 rst_n dropped in WAIT, ack arrives during reset -> instr=0, pc=RESET_PC, fresh fetch after release.

Source files
------------

// File: rtl/instr_fetch_unit_pkg.sv
// rtl/instr_fetch_unit_pkg.sv - shared encodings and types for the instruction fetch path
//
// Purpose: pcsource encodings shared with the control unit, the default reset
// PC, the fetch FSM state type and a sign-extension helper.
// Ports: none (package).

package instr_fetch_unit_pkg;

  localparam logic [1:0] PCSRC_SEQ = 2'b00;
  localparam logic [1:0] PCSRC_BR  = 2'b01;
  localparam logic [1:0] PCSRC_JR  = 2'b10;
  localparam logic [1:0] PCSRC_J   = 2'b11;

  localparam logic [31:0] RESET_PC_DEFAULT = 32'h0000_0000;

  typedef enum logic [1:0] {
    S_FETCH = 2'd0,
    S_WAIT  = 2'd1,
    S_EXEC  = 2'd2
  } fetch_state_t;

  function automatic logic [31:0] sext16(input logic [15:0] v);
    return {{16{v[15]}}, v};
  endfunction

endpackage

// File: rtl/instr_fetch_unit_if.sv
// rtl/instr_fetch_unit_if.sv - instruction memory read bus
//
// Purpose: groups the instruction memory request/acknowledge signals.
// Signals: imem_req   - read request (master -> slave)
//          imem_addr  - word-aligned read address (master -> slave)
//          imem_ack   - read data valid (slave -> master)
//          imem_rdata - instruction word (slave -> master)
// Modports: master (fetch unit), slave (instruction memory).

interface instr_fetch_unit_if;

  logic        imem_req;
  logic [31:0] imem_addr;
  logic        imem_ack;
  logic [31:0] imem_rdata;

  modport master (
    output imem_req,
    output imem_addr,
    input  imem_ack,
    input  imem_rdata
  );

  modport slave (
    input  imem_req,
    input  imem_addr,
    output imem_ack,
    output imem_rdata
  );

endinterface

// File: rtl/instr_fetch_unit_next_pc_gen.sv
// rtl/instr_fetch_unit_next_pc_gen.sv - combinational next-PC selection
//
// Purpose: computes pc+4 and the next PC for each pcsource selection, and
// flags a misaligned jr target.
// Ports: pc (in 32), pcsource (in 2), imm16 (in 16), target26 (in 26),
//        jr_addr (in 32), pc_plus4 (out 32), next_pc (out 32),
//        jr_misaligned (out 1).

module next_pc_gen
  import instr_fetch_unit_pkg::*;
(
  input  logic [31:0] pc,
  input  logic [1:0]  pcsource,
  input  logic [15:0] imm16,
  input  logic [25:0] target26,
  input  logic [31:0] jr_addr,
  output logic [31:0] pc_plus4,
  output logic [31:0] next_pc,
  output logic        jr_misaligned
);

  // All arithmetic wraps modulo 2^32; overflow is not an error.
  assign pc_plus4 = pc + 32'd4;

  always_comb begin
    next_pc = pc_plus4;
    case (pcsource)
      PCSRC_SEQ: next_pc = pc_plus4;
      PCSRC_BR:  next_pc = pc_plus4 + (sext16(imm16) << 2);
      PCSRC_JR:  next_pc = {jr_addr[31:2], 2'b00};
      PCSRC_J:   next_pc = {pc_plus4[31:28], target26, 2'b00};
      default:   next_pc = pc_plus4;
    endcase
  end

  // The jump still goes to the truncated target; this only reports it.
  assign jr_misaligned = (pcsource == PCSRC_JR) && (jr_addr[1:0] != 2'b00);

endmodule

// File: rtl/instr_fetch_unit.sv
// rtl/instr_fetch_unit.sv - instruction fetch FSM, PC and instruction register
//
// Purpose: fetches the instruction at pc over the imem bus, holds it for the
// datapath until advance, then moves pc to the selected next PC.
// Ports: clk, rst_n (async active-low)
//        pcsource, imm16, target26, jr_addr - next-PC selection inputs
//        advance  - datapath finished the current instruction
//        imem     - instruction memory bus (master modport)
//        instr, op, func, instr_valid, pc, pc_plus4 - current instruction view
//        addr_err - one-cycle pulse after a misaligned jr advance
//        fetch_err - sticky memory timeout flag

module instr_fetch_unit
  import instr_fetch_unit_pkg::*;
#(
  parameter logic [31:0] RESET_PC     = RESET_PC_DEFAULT,
  parameter int          IMEM_LAT_MAX = 8
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic [1:0]          pcsource,
  input  logic [15:0]         imm16,
  input  logic [25:0]         target26,
  input  logic [31:0]         jr_addr,
  input  logic                advance,
  instr_fetch_unit_if.master  imem,
  output logic [31:0]         instr,
  output logic [5:0]          op,
  output logic [5:0]          func,
  output logic                instr_valid,
  output logic [31:0]         pc,
  output logic [31:0]         pc_plus4,
  output logic                addr_err,
  output logic                fetch_err
);

  localparam int CW = $clog2(IMEM_LAT_MAX + 1);
  localparam logic [CW-1:0] LAT_MAX = CW'(IMEM_LAT_MAX);

  fetch_state_t  state, state_next;
  logic          req_en;
  logic          req;
  logic          load_instr;
  logic          do_advance;
  logic [31:0]   next_pc;
  logic          jr_misaligned;
  logic [CW-1:0] lat_cnt;
  logic [CW-1:0] lat_cnt_inc;

  next_pc_gen u_next_pc_gen (
    .pc            (pc),
    .pcsource      (pcsource),
    .imm16         (imm16),
    .target26      (target26),
    .jr_addr       (jr_addr),
    .pc_plus4      (pc_plus4),
    .next_pc       (next_pc),
    .jr_misaligned (jr_misaligned)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= S_FETCH;
    else        state <= state_next;
  end

  // req_en keeps the request low during reset and the first cycle after
  // release, even though the state is already FETCH; an ack that arrives
  // then is not taken.
  always_comb begin
    state_next = state;
    req        = 1'b0;
    load_instr = 1'b0;
    do_advance = 1'b0;
    case (state)
      S_FETCH: begin
        if (req_en) begin
          req = 1'b1;
          if (imem.imem_ack) begin
            load_instr = 1'b1;
            state_next = S_EXEC;
          end else begin
            state_next = S_WAIT;
          end
        end
      end
      S_WAIT: begin
        req = 1'b1;
        if (imem.imem_ack) begin
          load_instr = 1'b1;
          state_next = S_EXEC;
        end
      end
      S_EXEC: begin
        if (advance) begin
          do_advance = 1'b1;
          state_next = S_FETCH;
        end
      end
      default: state_next = S_FETCH;
    endcase
  end

  // Counts request cycles that went unanswered, saturating at the limit.
  assign lat_cnt_inc = (lat_cnt == LAT_MAX) ? lat_cnt : lat_cnt + CW'(1);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      req_en    <= 1'b0;
      pc        <= RESET_PC;
      instr     <= 32'h0;
      addr_err  <= 1'b0;
      fetch_err <= 1'b0;
      lat_cnt   <= '0;
    end else begin
      req_en   <= 1'b1;
      addr_err <= do_advance && jr_misaligned;
      if (do_advance) pc <= next_pc;
      if (load_instr) instr <= imem.imem_rdata;
      if (load_instr || !req) begin
        lat_cnt <= '0;
      end else begin
        lat_cnt <= lat_cnt_inc;
        if (lat_cnt_inc == LAT_MAX) fetch_err <= 1'b1;
      end
    end
  end

  assign imem.imem_req  = req;
  assign imem.imem_addr = pc;
  assign instr_valid    = (state == S_EXEC);
  assign op             = instr[31:26];
  assign func           = instr[5:0];

endmodule
